// File: rtl/ei_axi4_wr_slave_mem.sv
// AXI4 write-only slave backed by a byte-maskable word memory, one burst in flight.
// A combinational backdoor port reads any word for inspection.
module ei_axi4_wr_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    rdy_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic                    fixed_q;
    logic                    bad_burst_q;
    logic                    slverr_q;
    logic                    decerr_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic aw_hs, w_hs, last_beat, in_range;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign last_beat = (cnt_q == len_q);
    assign in_range  = ({1'b0, idx_q} < DEPTH_L);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    // rdy_q keeps awready low on reset edges and raises it one edge after release
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                awready = rdy_q;
                if (awvalid && rdy_q) state_d = DATA;
            end
            DATA: begin
                wready = 1'b1;
                if (wvalid && last_beat) state_d = RESP;
            end
            RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            id_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            fixed_q     <= 1'b0;
            bad_burst_q <= 1'b0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
        end else if (aw_hs) begin
            id_q        <= awid;
            idx_q       <= awaddr >> OFFS;
            len_q       <= awlen;
            cnt_q       <= '0;
            fixed_q     <= (awburst == 2'b00);
            bad_burst_q <= awburst[1];
            slverr_q    <= awburst[1];
            decerr_q    <= 1'b0;
        end else if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (!fixed_q) idx_q <= idx_q + 1'b1;
            if (!in_range) decerr_q <= 1'b1;
            if (wlast != last_beat) slverr_q <= 1'b1;
        end
    end

    // Memory is deliberately not reset; a beat accepted on a reset edge is dropped.
    always_ff @(posedge aclk) begin
        if (!areset && w_hs && !bad_burst_q && in_range) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[idx_q[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign bid       = id_q;
    assign bresp     = decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_ei_axi4_wr_slave_mem.sv
// Directed bench: stimulus pushes expected B responses; a monitor pops them on each B handshake.
module tb_ei_axi4_wr_slave_mem;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;
    logic [5:0]  exp_q[$];
    logic [31:0] bd [256];
    logic [3:0]  bs [256];

    always #5 aclk = ~aclk;

    ei_axi4_wr_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(256)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input logic [7:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge aclk);
        check($sformatf("mem[%0d]", a), dbg_rdata, exp);
    endtask

    // Full burst from bd/bs; 'early' flips wlast on that beat index (-1 for none).
    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] bt, input int early, input logic [1:0] resp);
        int n;
        exp_q.push_back({id, resp});
        @(posedge aclk); #1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        check("awready_idle", {31'b0, awready}, 32'd1);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awburst = bt;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        check("wready_first", {31'b0, wready}, 32'd1);
        check("awready_data", {31'b0, awready}, 32'd0);
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = bd[i]; wstrb = bs[i];
            wlast  = (i == len) ^ (i == early);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_last", {31'b0, bvalid}, 32'd1);
        check("wready_resp", {31'b0, wready}, 32'd0);
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(negedge aclk);
            if (bvalid && bready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_b: got bid=%0d bresp=%0d expected no response", bid, bresp);
                end else begin
                    e = exp_q.pop_front();
                    check("bid", {28'b0, bid}, {28'b0, e[5:2]});
                    check("bresp", {30'b0, bresp}, {30'b0, e[1:0]});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; wdata = '0; wstrb = '0; dbg_addr = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready", {31'b0, wready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_bid", {28'b0, bid}, 32'd0);
        check("rst_bresp", {30'b0, bresp}, 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("awready_after_rst", {31'b0, awready}, 32'd1);

        // Clear words 0..9 so later partial writes have a known base
        for (int i = 0; i < 10; i++) begin bd[i] = 32'h0; bs[i] = 4'hF; end
        do_burst(4'd1, 32'h0, 9, 2'b01, -1, 2'b00);

        for (int i = 0; i < 4; i++) begin bd[i] = 32'hA0 + i; bs[i] = 4'hF; end
        do_burst(4'd3, 32'h10, 3, 2'b01, -1, 2'b00);
        chk_mem(8'd4, 32'hA0); chk_mem(8'd5, 32'hA1);
        chk_mem(8'd6, 32'hA2); chk_mem(8'd7, 32'hA3);

        bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333;
        bs[0] = 4'h1; bs[1] = 4'h2; bs[2] = 4'h4;
        do_burst(4'd5, 32'h0, 2, 2'b00, -1, 2'b00);
        chk_mem(8'd0, 32'h00332211);

        for (int i = 0; i < 4; i++) begin bd[i] = 32'hB0 + i; bs[i] = 4'hF; end
        do_burst(4'd6, 32'h3F8, 3, 2'b01, -1, 2'b11);
        chk_mem(8'd254, 32'hB0); chk_mem(8'd255, 32'hB1);
        chk_mem(8'd0, 32'h00332211); chk_mem(8'd1, 32'h0);

        bd[0] = 32'hDEADBEEF; bd[1] = 32'hCAFEF00D; bs[0] = 4'hF; bs[1] = 4'hF;
        do_burst(4'd7, 32'h20, 1, 2'b10, -1, 2'b10);
        chk_mem(8'd8, 32'h0); chk_mem(8'd9, 32'h0);

        bd[0] = 32'hC0; bd[1] = 32'hC1;
        do_burst(4'd2, 32'h40, 1, 2'b01, 0, 2'b10);
        chk_mem(8'd16, 32'hC0); chk_mem(8'd17, 32'hC1);

        // Response stall; a stray W beat during RESP must not land in word 8
        @(posedge aclk); #1;
        bready = 1'b0;
        bd[0] = 32'h12345678; bs[0] = 4'hF;
        do_burst(4'd9, 32'h1C, 0, 2'b01, -1, 2'b00);
        wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wlast = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk); #1;
            check("stall_bvalid", {31'b0, bvalid}, 32'd1);
            check("stall_bid", {28'b0, bid}, 32'd9);
            check("stall_bresp", {30'b0, bresp}, 32'd0);
            check("stall_awready", {31'b0, awready}, 32'd0);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(posedge aclk); #1;
        chk_mem(8'd7, 32'h12345678); chk_mem(8'd8, 32'h0);

        // Reset after two beats of an 8-beat burst: no response expected
        @(posedge aclk); #1;
        awvalid = 1'b1; awid = 4'd4; awaddr = 32'h100; awlen = 8'd7; awburst = 2'b01;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'hD0 + i; wstrb = 4'hF; wlast = 1'b0;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk); #1;
        check("midrst_bvalid", {31'b0, bvalid}, 32'd0);
        check("midrst_awready", {31'b0, awready}, 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("midrst_awready_rel", {31'b0, awready}, 32'd1);
        check("midrst_wready_rel", {31'b0, wready}, 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("midrst_no_b", {31'b0, bvalid}, 32'd0);
        chk_mem(8'd64, 32'hD0); chk_mem(8'd65, 32'hD1);

        for (int i = 0; i < 256; i++) begin bd[i] = 32'(i) ^ 32'h5A000000; bs[i] = 4'hF; end
        do_burst(4'd15, 32'h0, 255, 2'b01, -1, 2'b00);
        chk_mem(8'd0, 32'h5A000000); chk_mem(8'd128, 32'h5A000080);
        chk_mem(8'd255, 32'h5A0000FF);

        repeat (3) @(posedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
